// File: rtl/slot_scheduler_pkg.sv
// Shared types for the slot scheduler: per-slot state encoding and error flag bit positions.
package slot_scheduler_pkg;

    typedef enum logic [1:0] {
        SLOT_INVALID = 2'd0,
        SLOT_FREE    = 2'd1,
        SLOT_BUSY    = 2'd2
    } slot_state_e;

    localparam int ERR_W       = 2;
    localparam int ERR_BAD_PTR = 0;
    localparam int ERR_BAD_REL = 1;

endpackage

// File: rtl/slot_free_fifo.sv
// First-word-fall-through FIFO of free slot pointers; one push and one pop per cycle.
module slot_free_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    rd_ptr;
    logic [IW-1:0]    wr_ptr;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wrap_inc(wr_ptr);
            if (pop)
                rd_ptr <= wrap_inc(rd_ptr);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (!push && pop)
                count <= count - CNT_W'(1);
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/slot_scheduler.sv
// Per-core packet-slot manager: firmware-programmed slot address LUT, free-slot handout to
// ingress and slot reclaim on release, with sticky error reporting.
module slot_scheduler
    import slot_scheduler_pkg::*;
#(
    parameter int SLOT_COUNT = 8,
    parameter int SLOT_WIDTH = $clog2(SLOT_COUNT + 1),
    parameter int ADDR_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slot_wr_valid,
    output logic                  slot_wr_ready,
    input  logic [SLOT_WIDTH-1:0] slot_wr_ptr,
    input  logic [ADDR_WIDTH-1:0] slot_wr_addr,
    input  logic                  slot_for_hdr,
    output logic                  alloc_valid,
    input  logic                  alloc_ready,
    output logic [SLOT_WIDTH-1:0] alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic [ADDR_WIDTH-1:0] alloc_hdr_addr,
    input  logic                  rel_valid,
    input  logic [SLOT_WIDTH-1:0] rel_slot,
    output logic [SLOT_WIDTH-1:0] free_count,
    output logic [SLOT_COUNT-1:0] busy_mask,
    output logic [ERR_W-1:0]      err_flags,
    input  logic [ERR_W-1:0]      err_clr
);

    localparam int IDX_W = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

    slot_state_e           state    [SLOT_COUNT];
    logic [ADDR_WIDTH-1:0] data_tbl [SLOT_COUNT];
    logic [ADDR_WIDTH-1:0] hdr_tbl  [SLOT_COUNT];

    logic                  wr_fire, wr_ok, wr_new;
    logic                  rel_ok, pop, push;
    logic [SLOT_WIDTH-1:0] push_slot, head_slot;
    logic [IDX_W-1:0]      wr_idx, rel_idx, head_idx;
    logic                  fifo_empty;
    logic [ERR_W-1:0]      err_set;

    // Pointer 0 is NULL, so pointer p lives at table index p-1.
    function automatic logic in_range(input logic [SLOT_WIDTH-1:0] ptr);
        return (ptr != '0) && (ptr <= SLOT_WIDTH'(SLOT_COUNT));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [SLOT_WIDTH-1:0] ptr);
        return IDX_W'(ptr - SLOT_WIDTH'(1));
    endfunction

    // Stalling writes during a release keeps the free FIFO to a single push per cycle.
    assign slot_wr_ready = !rel_valid;
    assign wr_fire       = slot_wr_valid && slot_wr_ready;
    assign wr_ok         = in_range(slot_wr_ptr);
    assign wr_idx        = to_idx(slot_wr_ptr);
    assign rel_idx       = to_idx(rel_slot);
    assign head_idx      = to_idx(head_slot);

    assign pop    = !fifo_empty && alloc_ready;
    assign wr_new = wr_fire && wr_ok && !slot_for_hdr && (state[wr_idx] == SLOT_INVALID);
    // The slot at the FIFO head is FREE, so releasing it while it is being popped is an error.
    assign rel_ok = rel_valid && in_range(rel_slot) && (state[rel_idx] == SLOT_BUSY);
    assign push      = wr_new || rel_ok;
    assign push_slot = rel_ok ? rel_slot : slot_wr_ptr;

    always_comb begin
        err_set              = '0;
        err_set[ERR_BAD_PTR] = wr_fire && !wr_ok;
        err_set[ERR_BAD_REL] = rel_valid && !rel_ok;
    end

    slot_free_fifo #(
        .DEPTH (SLOT_COUNT),
        .WIDTH (SLOT_WIDTH),
        .CNT_W (SLOT_WIDTH)
    ) u_free_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_slot),
        .pop       (pop),
        .head      (head_slot),
        .empty     (fifo_empty),
        .count     (free_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOT_COUNT; i++)
                state[i] <= SLOT_INVALID;
        end else begin
            if (wr_new)
                state[wr_idx] <= SLOT_FREE;
            if (pop)
                state[head_idx] <= SLOT_BUSY;
            if (rel_ok)
                state[rel_idx] <= SLOT_FREE;
        end
    end

    // Address tables hold no reset: a slot is unreadable until its data address makes it FREE.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_ok) begin
            if (slot_for_hdr)
                hdr_tbl[wr_idx] <= slot_wr_addr;
            else
                data_tbl[wr_idx] <= slot_wr_addr;
        end
    end

    // A new error in the same cycle as its clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst)
            err_flags <= '0;
        else
            err_flags <= (err_flags & ~err_clr) | err_set;
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < SLOT_COUNT; i++)
            busy_mask[i] = (state[i] == SLOT_BUSY);
    end

    assign alloc_valid    = !fifo_empty;
    assign alloc_slot     = fifo_empty ? '0 : head_slot;
    assign alloc_addr     = fifo_empty ? '0 : data_tbl[head_idx];
    assign alloc_hdr_addr = fifo_empty ? '0 : hdr_tbl[head_idx];

endmodule

// File: tb/tb_slot_scheduler.sv
// Directed self-checking bench for slot_scheduler: config, allocation order, release, errors, stalls.
module tb_slot_scheduler;

    localparam int SC = 8;
    localparam int SW = 4;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic          slot_wr_valid;
    logic          slot_wr_ready;
    logic [SW-1:0] slot_wr_ptr;
    logic [AW-1:0] slot_wr_addr;
    logic          slot_for_hdr;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [SW-1:0] alloc_slot;
    logic [AW-1:0] alloc_addr;
    logic [AW-1:0] alloc_hdr_addr;
    logic          rel_valid;
    logic [SW-1:0] rel_slot;
    logic [SW-1:0] free_count;
    logic [SC-1:0] busy_mask;
    logic [1:0]    err_flags;
    logic [1:0]    err_clr;

    int total = 0;
    int bad   = 0;

    slot_scheduler #(.SLOT_COUNT(SC), .SLOT_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .slot_wr_valid  (slot_wr_valid),
        .slot_wr_ready  (slot_wr_ready),
        .slot_wr_ptr    (slot_wr_ptr),
        .slot_wr_addr   (slot_wr_addr),
        .slot_for_hdr   (slot_for_hdr),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_slot     (alloc_slot),
        .alloc_addr     (alloc_addr),
        .alloc_hdr_addr (alloc_hdr_addr),
        .rel_valid      (rel_valid),
        .rel_slot       (rel_slot),
        .free_count     (free_count),
        .busy_mask      (busy_mask),
        .err_flags      (err_flags),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        slot_wr_valid = 1'b0;
        slot_wr_ptr   = '0;
        slot_wr_addr  = '0;
        slot_for_hdr  = 1'b0;
        alloc_ready   = 1'b0;
        rel_valid     = 1'b0;
        rel_slot      = '0;
        err_clr       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [SW-1:0] ptr, input logic [AW-1:0] addr, input logic hdr);
        slot_wr_valid = 1'b1;
        slot_wr_ptr   = ptr;
        slot_wr_addr  = addr;
        slot_for_hdr  = hdr;
        tick();
        slot_wr_valid = 1'b0;
    endtask

    task automatic take();
        alloc_ready = 1'b1;
        tick();
        alloc_ready = 1'b0;
    endtask

    task automatic rel(input logic [SW-1:0] s);
        rel_valid = 1'b1;
        rel_slot  = s;
        tick();
        rel_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL reset_alloc_valid got=%0b exp=0", alloc_valid); end
        total++; if (free_count !== 4'd0) begin bad++; $display("FAIL reset_free_count got=%0d exp=0", free_count); end
        total++; if (busy_mask !== 8'h00) begin bad++; $display("FAIL reset_busy_mask got=%h exp=00", busy_mask); end
        total++; if (err_flags !== 2'b00) begin bad++; $display("FAIL reset_err_flags got=%b exp=00", err_flags); end
        total++; if (slot_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%0b exp=1", slot_wr_ready); end
    endtask

    task automatic test_data_alloc();
        do_reset();
        wr(4'd1, 25'h1000000, 1'b0);
        total++; if (alloc_valid !== 1'b1 || alloc_slot !== 4'd1) begin bad++; $display("FAIL first_offer got v=%0b s=%0d exp v=1 s=1", alloc_valid, alloc_slot); end
        total++; if (alloc_addr !== 25'h1000000) begin bad++; $display("FAIL first_addr got=%h exp=1000000", alloc_addr); end
        wr(4'd2, 25'h1010000, 1'b0);
        total++; if (free_count !== 4'd2 || alloc_slot !== 4'd1) begin bad++; $display("FAIL two_free got cnt=%0d s=%0d exp cnt=2 s=1", free_count, alloc_slot); end
        take();
        total++; if (free_count !== 4'd1 || alloc_slot !== 4'd2 || alloc_addr !== 25'h1010000) begin bad++; $display("FAIL pop1 got cnt=%0d s=%0d a=%h exp cnt=1 s=2 a=1010000", free_count, alloc_slot, alloc_addr); end
        total++; if (busy_mask !== 8'h01) begin bad++; $display("FAIL pop1_busy got=%h exp=01", busy_mask); end
        tick();
        total++; if (alloc_valid !== 1'b1 || alloc_slot !== 4'd2) begin bad++; $display("FAIL hold_stable got v=%0b s=%0d exp v=1 s=2", alloc_valid, alloc_slot); end
        take();
        total++; if (free_count !== 4'd0 || alloc_valid !== 1'b0 || busy_mask !== 8'h03) begin bad++; $display("FAIL pop2 got cnt=%0d v=%0b busy=%h exp 0 0 03", free_count, alloc_valid, busy_mask); end
    endtask

    task automatic test_hdr_then_release();
        do_reset();
        wr(4'd1, 25'h0008000, 1'b1);
        total++; if (free_count !== 4'd0 || alloc_valid !== 1'b0) begin bad++; $display("FAIL hdr_no_push got cnt=%0d v=%0b exp 0 0", free_count, alloc_valid); end
        wr(4'd1, 25'h1000000, 1'b0);
        total++; if (alloc_slot !== 4'd1 || alloc_hdr_addr !== 25'h0008000) begin bad++; $display("FAIL hdr_addr got s=%0d h=%h exp s=1 h=0008000", alloc_slot, alloc_hdr_addr); end
        wr(4'd2, 25'h1010000, 1'b0);
        take();
        total++; if (busy_mask !== 8'h01) begin bad++; $display("FAIL rel_busy_set got=%h exp=01", busy_mask); end
        rel(4'd1);
        total++; if (busy_mask !== 8'h00 || free_count !== 4'd2 || alloc_slot !== 4'd2) begin bad++; $display("FAIL rel_cleared got busy=%h cnt=%0d s=%0d exp 00 2 2", busy_mask, free_count, alloc_slot); end
        take();
        total++; if (alloc_slot !== 4'd1 || alloc_addr !== 25'h1000000) begin bad++; $display("FAIL fifo_order got s=%0d a=%h exp s=1 a=1000000", alloc_slot, alloc_addr); end
        total++; if (err_flags !== 2'b00) begin bad++; $display("FAIL rel_no_err got=%b exp=00", err_flags); end
    endtask

    task automatic test_errors();
        do_reset();
        wr(4'd3, 25'h0030000, 1'b0);
        rel(4'd3);
        total++; if (err_flags !== 2'b10 || free_count !== 4'd1) begin bad++; $display("FAIL rel_free_err got e=%b cnt=%0d exp e=10 cnt=1", err_flags, free_count); end
        wr(4'd0, 25'h0000100, 1'b0);
        total++; if (err_flags !== 2'b11 || free_count !== 4'd1) begin bad++; $display("FAIL null_ptr_err got e=%b cnt=%0d exp e=11 cnt=1", err_flags, free_count); end
        err_clr = 2'b01;
        tick();
        err_clr = 2'b00;
        total++; if (err_flags !== 2'b10) begin bad++; $display("FAIL clr_bit0 got=%b exp=10", err_flags); end
        err_clr   = 2'b10;
        rel_valid = 1'b1;
        rel_slot  = 4'd3;
        tick();
        err_clr   = 2'b00;
        rel_valid = 1'b0;
        total++; if (err_flags !== 2'b10) begin bad++; $display("FAIL err_wins got=%b exp=10", err_flags); end
        err_clr = 2'b11;
        tick();
        err_clr = 2'b00;
        total++; if (err_flags !== 2'b00) begin bad++; $display("FAIL clr_all got=%b exp=00", err_flags); end
        wr(4'd9, 25'h0090000, 1'b0);
        total++; if (err_flags !== 2'b01 || free_count !== 4'd1) begin bad++; $display("FAIL ptr9_err got e=%b cnt=%0d exp e=01 cnt=1", err_flags, free_count); end
        wr(4'd8, 25'h0080000, 1'b0);
        total++; if (free_count !== 4'd2 || err_flags !== 2'b01) begin bad++; $display("FAIL ptr8_ok got cnt=%0d e=%b exp cnt=2 e=01", free_count, err_flags); end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] exp_order [5];
        exp_order[0] = 4'd5; exp_order[1] = 4'd6; exp_order[2] = 4'd7;
        exp_order[3] = 4'd8; exp_order[4] = 4'd1;
        do_reset();
        for (int i = 1; i <= SC; i++)
            wr(SW'(i), AW'(i) << 12, 1'b0);
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL all_free got=%0d exp=8", free_count); end
        take();
        take();
        total++; if (busy_mask !== 8'h03 || free_count !== 4'd6 || alloc_slot !== 4'd3) begin bad++; $display("FAIL two_taken got busy=%h cnt=%0d s=%0d exp 03 6 3", busy_mask, free_count, alloc_slot); end
        alloc_ready = 1'b1;
        rel_valid   = 1'b1;
        rel_slot    = 4'd1;
        tick();
        total++; if (free_count !== 4'd6 || busy_mask !== 8'h06 || alloc_slot !== 4'd4) begin bad++; $display("FAIL pop_push got cnt=%0d busy=%h s=%0d exp 6 06 4", free_count, busy_mask, alloc_slot); end
        total++; if (alloc_addr !== 25'h0004000) begin bad++; $display("FAIL pop_push_addr got=%h exp=0004000", alloc_addr); end
        rel_slot = 4'd4;
        tick();
        alloc_ready = 1'b0;
        rel_valid   = 1'b0;
        total++; if (err_flags !== 2'b10 || free_count !== 4'd5 || busy_mask !== 8'h0e) begin bad++; $display("FAIL rel_head got e=%b cnt=%0d busy=%h exp 10 5 0e", err_flags, free_count, busy_mask); end
        for (int i = 0; i < 5; i++) begin
            total++; if (alloc_valid !== 1'b1 || alloc_slot !== exp_order[i]) begin bad++; $display("FAIL drain_%0d got v=%0b s=%0d exp v=1 s=%0d", i, alloc_valid, alloc_slot, exp_order[i]); end
            take();
        end
        total++; if (alloc_valid !== 1'b0 || busy_mask !== 8'hff || free_count !== 4'd0) begin bad++; $display("FAIL drained got v=%0b busy=%h cnt=%0d exp 0 ff 0", alloc_valid, busy_mask, free_count); end
    endtask

    task automatic test_wr_stall_and_reset();
        do_reset();
        rel_valid     = 1'b1;
        rel_slot      = 4'd5;
        slot_wr_valid = 1'b1;
        slot_wr_ptr   = 4'd1;
        slot_wr_addr  = 25'h1000000;
        slot_for_hdr  = 1'b0;
        #1;
        total++; if (slot_wr_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0b exp=0", slot_wr_ready); end
        tick();
        total++; if (free_count !== 4'd0 || err_flags !== 2'b10) begin bad++; $display("FAIL stall_no_write got cnt=%0d e=%b exp 0 10", free_count, err_flags); end
        rel_valid = 1'b0;
        #1;
        total++; if (slot_wr_ready !== 1'b1) begin bad++; $display("FAIL retry_ready got=%0b exp=1", slot_wr_ready); end
        tick();
        slot_wr_valid = 1'b0;
        total++; if (free_count !== 4'd1 || alloc_slot !== 4'd1) begin bad++; $display("FAIL retry_write got cnt=%0d s=%0d exp 1 1", free_count, alloc_slot); end
        wr(4'd2, 25'h1010000, 1'b0);
        take();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy_mask !== 8'h00 || free_count !== 4'd0 || alloc_valid !== 1'b0 || err_flags !== 2'b00) begin bad++; $display("FAIL mid_reset got busy=%h cnt=%0d v=%0b e=%b exp 00 0 0 00", busy_mask, free_count, alloc_valid, err_flags); end
        wr(4'd2, 25'h1010000, 1'b1);
        total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL post_reset_invalid got v=%0b exp=0", alloc_valid); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_data_alloc();
        test_hdr_then_release();
        test_errors();
        test_back_to_back();
        test_wr_stall_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
